// File: rtl/vending_sequencer_if.sv
// User-side bundle of the vending sequencer: coin/select/return inputs
// plus the dispense, change, total, timer and state outputs.
interface vending_sequencer_if #(
  parameter int NUM_COINS  = 3,
  parameter int NUM_ITEMS  = 4,
  parameter int TOTAL_BITS = 31
);
  logic [NUM_COINS-1:0]  i_input_coin;
  logic [NUM_ITEMS-1:0]  i_select_item;
  logic                  i_trigger_return;
  logic [NUM_ITEMS-1:0]  o_available_item;
  logic [NUM_ITEMS-1:0]  o_output_item;
  logic [NUM_COINS-1:0]  o_return_coin;
  logic [TOTAL_BITS-1:0] o_total;
  logic [31:0]           o_wait_time;
  logic [1:0]            o_state;

  // Driver of the user inputs (environment / front panel)
  modport master (
    output i_input_coin, i_select_item, i_trigger_return,
    input  o_available_item, o_output_item, o_return_coin,
           o_total, o_wait_time, o_state
  );

  // The sequencer itself
  modport slave (
    input  i_input_coin, i_select_item, i_trigger_return,
    output o_available_item, o_output_item, o_return_coin,
           o_total, o_wait_time, o_state
  );
endinterface

// File: rtl/vending_sequencer.sv
// Vending machine control FSM: accumulates coins into a running total,
// gates item availability, sequences a one-cycle dispense, runs the
// inactivity timeout and pays change back largest coin first.
module vending_sequencer #(
  parameter int NUM_COINS    = 3,
  parameter int NUM_ITEMS    = 4,
  parameter int TOTAL_BITS   = 31,
  parameter int WAIT_TIME    = 100,
  parameter int COIN_VAL0    = 100,
  parameter int COIN_VAL1    = 500,
  parameter int COIN_VAL2    = 1000,
  parameter int ITEM_PRICE0  = 400,
  parameter int ITEM_PRICE1  = 500,
  parameter int ITEM_PRICE2  = 1000,
  parameter int ITEM_PRICE3  = 2000,
  parameter int MAX_TOTAL    = 5000
) (
  input logic                clk,
  input logic                reset,
  vending_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    RETURN   = 2'd3
  } state_t;

  typedef logic [TOTAL_BITS-1:0] total_t;

  // Coin value lookup; denominations are ascending by index.
  function automatic total_t coin_val(input int k);
    case (k)
      0:       coin_val = total_t'(COIN_VAL0);
      1:       coin_val = total_t'(COIN_VAL1);
      2:       coin_val = total_t'(COIN_VAL2);
      default: coin_val = '0;
    endcase
  endfunction

  function automatic total_t item_price(input int i);
    case (i)
      0:       item_price = total_t'(ITEM_PRICE0);
      1:       item_price = total_t'(ITEM_PRICE1);
      2:       item_price = total_t'(ITEM_PRICE2);
      3:       item_price = total_t'(ITEM_PRICE3);
      default: item_price = '0;
    endcase
  endfunction

  // Accept a coin only if the new total stays within the ceiling; the
  // sum is formed one bit wider so it can never wrap.
  function automatic logic coin_fits(input total_t total, input total_t val);
    logic [TOTAL_BITS:0] sum;
    sum = {1'b0, total} + {1'b0, val};
    coin_fits = (sum <= (TOTAL_BITS+1)'(MAX_TOTAL));
  endfunction

  state_t                state_q, state_d;
  total_t                total_q, total_d;
  logic [31:0]           wait_q, wait_d;
  logic [NUM_ITEMS-1:0]  item_q, item_d;
  logic [NUM_COINS-1:0]  ret_q, ret_d;

  logic                  coin_valid;
  logic                  sel_valid;
  logic                  sel_hit;
  total_t                coin_value;
  total_t                sel_price;
  logic [NUM_ITEMS-1:0]  avail;
  logic [NUM_COINS-1:0]  change_coin;
  total_t                change_value;

  // Decode inputs, availability and the greedy change coin.
  always_comb begin
    coin_valid   = $onehot(bus.i_input_coin);
    sel_valid    = $onehot(bus.i_select_item);
    coin_value   = '0;
    sel_price    = '0;
    avail        = '0;
    change_coin  = '0;
    change_value = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (bus.i_input_coin[k]) coin_value = coin_val(k);
      // Ascending denominations: the last fitting coin is the largest.
      if (coin_val(k) <= total_q) begin
        change_coin  = '0;
        change_coin[k] = 1'b1;
        change_value = coin_val(k);
      end
    end
    for (int i = 0; i < NUM_ITEMS; i++) begin
      avail[i] = (state_q == COLLECT) && (total_q >= item_price(i));
      if (bus.i_select_item[i]) sel_price = item_price(i);
    end
    sel_hit = sel_valid && ((bus.i_select_item & avail) != '0);
  end

  // Next-state and output logic; priority in COLLECT is return > select > coin.
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    wait_d  = wait_q;
    item_d  = '0;
    ret_d   = '0;
    case (state_q)
      IDLE: begin
        if (coin_valid) begin
          total_d = total_q + coin_value;
          wait_d  = 32'(WAIT_TIME);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.i_trigger_return) begin
          state_d = RETURN;
        end else if (sel_hit) begin
          item_d  = bus.i_select_item;
          total_d = total_q - sel_price;
          wait_d  = 32'(WAIT_TIME);
          state_d = DISPENSE;
        end else if (coin_valid) begin
          if (coin_fits(total_q, coin_value)) total_d = total_q + coin_value;
          wait_d = 32'(WAIT_TIME);
        end else begin
          wait_d = wait_q - 32'd1;
          if (wait_q == 32'd1) state_d = RETURN;
        end
      end
      DISPENSE: begin
        state_d = (total_q != '0) ? COLLECT : IDLE;
      end
      RETURN: begin
        if (total_q != '0) begin
          ret_d   = change_coin;
          total_d = total_q - change_value;
        end else begin
          wait_d  = 32'(WAIT_TIME);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any pending change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      total_q <= '0;
      wait_q  <= 32'(WAIT_TIME);
      item_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      wait_q  <= wait_d;
      item_q  <= item_d;
      ret_q   <= ret_d;
    end
  end

  assign bus.o_available_item = avail;
  assign bus.o_output_item    = item_q;
  assign bus.o_return_coin    = ret_q;
  assign bus.o_total          = total_q;
  assign bus.o_wait_time      = wait_q;
  assign bus.o_state          = state_q;

endmodule

// File: tb/tb_vending_sequencer.sv
// Bench for vending_sequencer: directed stimulus pushes expected dispense
// and change events into queues; a negedge monitor pops and compares them.
module tb_vending_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [2:0]  coin;
    logic [30:0] total;
  } coin_exp_t;

  logic [3:0] exp_item_q[$];
  coin_exp_t  exp_coin_q[$];

  vending_sequencer_if #(.NUM_COINS(3), .NUM_ITEMS(4), .TOTAL_BITS(31)) bus ();

  vending_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input logic [2:0] c, input logic [3:0] s, input logic r);
    bus.i_input_coin     = c;
    bus.i_select_item    = s;
    bus.i_trigger_return = r;
    @(posedge clk);
    #1;
    bus.i_input_coin     = '0;
    bus.i_select_item    = '0;
    bus.i_trigger_return = 1'b0;
  endtask

  task automatic push_coin(input logic [2:0] c, input logic [30:0] t);
    coin_exp_t e;
    e.coin  = c;
    e.total = t;
    exp_coin_q.push_back(e);
  endtask

  // Monitor: every dispense pulse or change coin must match the next expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.o_output_item != 4'b0) begin
        if (exp_item_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dispense: got %b expected none", bus.o_output_item);
        end else begin
          chk("dispense_item", 32'(bus.o_output_item), 32'(exp_item_q.pop_front()));
        end
      end
      if (bus.o_return_coin != 3'b0) begin
        if (exp_coin_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_change: got %b expected none", bus.o_return_coin);
        end else begin
          coin_exp_t e;
          e = exp_coin_q.pop_front();
          chk("change_coin", 32'(bus.o_return_coin), 32'(e.coin));
          chk("change_total", 32'(bus.o_total), 32'(e.total));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset with coin and select held active
    reset = 1'b1;
    bus.i_input_coin     = 3'b010;
    bus.i_select_item    = 4'b0001;
    bus.i_trigger_return = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_state", 32'(bus.o_state), 0);
    chk("rst_total", 32'(bus.o_total), 0);
    chk("rst_wait", bus.o_wait_time, 100);
    chk("rst_item", 32'(bus.o_output_item), 0);
    chk("rst_coin", 32'(bus.o_return_coin), 0);
    reset = 1'b0;
    bus.i_input_coin  = '0;
    bus.i_select_item = '0;

    // 500 + 500 then buy item1 (500)
    step(3'b010, 4'b0, 1'b0);
    chk("c1_state", 32'(bus.o_state), 1);
    chk("c1_total", 32'(bus.o_total), 500);
    chk("c1_avail", 32'(bus.o_available_item), 32'b0011);
    step(3'b010, 4'b0, 1'b0);
    chk("c2_total", 32'(bus.o_total), 1000);
    chk("c2_avail", 32'(bus.o_available_item), 32'b0111);
    exp_item_q.push_back(4'b0010);
    step(3'b000, 4'b0010, 1'b0);
    chk("sel_state", 32'(bus.o_state), 2);
    chk("sel_total", 32'(bus.o_total), 500);
    chk("sel_item", 32'(bus.o_output_item), 32'b0010);
    step(3'b000, 4'b0, 1'b0);
    chk("post_sel_state", 32'(bus.o_state), 1);
    chk("post_sel_item", 32'(bus.o_output_item), 0);
    chk("post_sel_avail", 32'(bus.o_available_item), 32'b0011);
    chk("post_sel_wait", bus.o_wait_time, 100);

    // Bring total to 1600 and request return
    step(3'b100, 4'b0, 1'b0);
    step(3'b001, 4'b0, 1'b0);
    chk("t1600_total", 32'(bus.o_total), 1600);
    push_coin(3'b100, 31'd600);
    push_coin(3'b010, 31'd100);
    push_coin(3'b001, 31'd0);
    step(3'b000, 4'b0, 1'b1);
    chk("ret_state", 32'(bus.o_state), 3);
    chk("ret_total", 32'(bus.o_total), 1600);
    step(3'b000, 4'b0, 1'b0);
    step(3'b000, 4'b0, 1'b0);
    step(3'b000, 4'b0, 1'b0);
    chk("ret_last_total", 32'(bus.o_total), 0);
    step(3'b000, 4'b0, 1'b0);
    chk("ret_idle_state", 32'(bus.o_state), 0);
    chk("ret_idle_coin", 32'(bus.o_return_coin), 0);
    chk("ret_idle_wait", bus.o_wait_time, 100);

    // Inactivity timeout after a 1000 coin
    step(3'b100, 4'b0, 1'b0);
    push_coin(3'b100, 31'd0);
    n = 0;
    while (bus.o_state != 2'd3 && n < 200) begin
      step(3'b000, 4'b0, 1'b0);
      n++;
    end
    chk("timeout_edges", n, 100);
    chk("timeout_wait", bus.o_wait_time, 0);
    step(3'b000, 4'b0, 1'b0);
    step(3'b000, 4'b0, 1'b0);
    chk("timeout_idle", 32'(bus.o_state), 0);
    chk("timeout_reload", bus.o_wait_time, 100);

    // Return beats select beats coin in the same cycle
    step(3'b010, 4'b0, 1'b0);
    push_coin(3'b010, 31'd0);
    step(3'b010, 4'b0001, 1'b1);
    chk("prio_state", 32'(bus.o_state), 3);
    chk("prio_total", 32'(bus.o_total), 500);
    chk("prio_item", 32'(bus.o_output_item), 0);
    step(3'b000, 4'b0, 1'b0);
    step(3'b000, 4'b0, 1'b0);
    chk("prio_idle", 32'(bus.o_state), 0);

    // Saturation at MAX_TOTAL
    step(3'b100, 4'b0, 1'b0);
    step(3'b100, 4'b0, 1'b0);
    step(3'b100, 4'b0, 1'b0);
    step(3'b100, 4'b0, 1'b0);
    step(3'b010, 4'b0, 1'b0);
    chk("sat_4500", 32'(bus.o_total), 4500);
    step(3'b000, 4'b0, 1'b0);
    step(3'b000, 4'b0, 1'b0);
    step(3'b000, 4'b0, 1'b0);
    chk("sat_wait_dec", bus.o_wait_time, 97);
    step(3'b100, 4'b0, 1'b0);
    chk("sat_drop_total", 32'(bus.o_total), 4500);
    chk("sat_drop_wait", bus.o_wait_time, 100);
    chk("sat_drop_state", 32'(bus.o_state), 1);
    step(3'b010, 4'b0, 1'b0);
    chk("sat_exact_max", 32'(bus.o_total), 5000);
    for (int i = 4; i >= 0; i--) push_coin(3'b100, 31'(i * 1000));
    step(3'b000, 4'b0, 1'b1);
    repeat (5) step(3'b000, 4'b0, 1'b0);
    step(3'b000, 4'b0, 1'b0);
    chk("sat_idle", 32'(bus.o_state), 0);
    chk("sat_idle_total", 32'(bus.o_total), 0);

    // Unavailable select and non-one-hot inputs count as no event
    step(3'b100, 4'b0, 1'b0);
    step(3'b010, 4'b0, 1'b0);
    chk("ua_total", 32'(bus.o_total), 1500);
    chk("ua_avail", 32'(bus.o_available_item), 32'b0111);
    step(3'b000, 4'b0, 1'b0);
    chk("ua_wait99", bus.o_wait_time, 99);
    step(3'b000, 4'b1000, 1'b0);
    chk("ua_sel_state", 32'(bus.o_state), 1);
    chk("ua_sel_total", 32'(bus.o_total), 1500);
    chk("ua_sel_wait", bus.o_wait_time, 98);
    step(3'b011, 4'b0, 1'b0);
    chk("multi_coin_total", 32'(bus.o_total), 1500);
    chk("multi_coin_wait", bus.o_wait_time, 97);
    step(3'b000, 4'b0011, 1'b0);
    chk("multi_sel_state", 32'(bus.o_state), 1);
    chk("multi_sel_wait", bus.o_wait_time, 96);
    push_coin(3'b100, 31'd500);
    push_coin(3'b010, 31'd0);
    step(3'b000, 4'b0, 1'b1);
    step(3'b000, 4'b0, 1'b0);
    step(3'b000, 4'b0, 1'b0);
    step(3'b000, 4'b0, 1'b0);
    chk("ua_idle", 32'(bus.o_state), 0);

    // Everything expected must have been observed
    step(3'b000, 4'b0, 1'b0);
    chk("sb_items_drained", exp_item_q.size(), 0);
    chk("sb_coins_drained", exp_coin_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
